// File: rtl/ysyx_22051086_axi_master.sv
// Cache-line burst initiator: one refill (INCR read burst) or write-back (INCR write burst)
// at a time, finished by a single-cycle response pulse back to the cache.
module ysyx_22051086_axi_master #(
    parameter int BEATS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wen_i,
    input  logic [31:0]           req_addr_i,
    input  logic [64*BEATS-1:0]   req_wdata_i,
    output logic                  resp_valid_o,
    output logic [64*BEATS-1:0]   resp_rdata_o,
    output logic                  resp_err_o,
    output logic [31:0]           araddr_o,
    output logic [3:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [63:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [31:0]           awaddr_o,
    output logic [3:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [63:0]           wdata_o,
    output logic [63:0]           wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    localparam int         ALIGN     = $clog2(8 * BEATS);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << ALIGN) - 32'd1);
    localparam int         IW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] LAST      = 4'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
    } state_e;

    state_e                   state_q;
    logic [BEATS-1:0][63:0]   line_q;
    logic [BEATS-1:0][63:0]   rbuf_q;
    logic [BEATS-1:0][63:0]   resp_rdata_q;
    logic [BEATS-1:0][63:0]   rline_d;
    logic [3:0]               cnt_q;
    logic [3:0]               cnt_d;
    logic                     err_q;
    logic [31:0]              araddr_q, awaddr_q;
    logic [3:0]               arlen_q, awlen_q;
    logic [2:0]               arsize_q, awsize_q;
    logic [1:0]               arburst_q, awburst_q;
    logic                     arvalid_q, awvalid_q, rready_q, wvalid_q, wlast_q, bready_q;
    logic [63:0]              wdata_q, wstrb_q;
    logic                     resp_valid_q, resp_err_q;
    logic                     rerr_s, berr_s;

    assign cnt_d  = cnt_q + 4'd1;
    assign rerr_s = (rresp_i != 2'b00);
    assign berr_s = (bresp_i != 2'b00);

    // Refill line as it will look once the beat currently on the R channel is absorbed.
    always_comb begin
        rline_d                    = rbuf_q;
        rline_d[cnt_q[IW-1:0]]     = rdata_i;
    end

    // Transaction FSM; every bus-facing output is a register updated on the state transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            rbuf_q       <= '0;
            resp_rdata_q <= '0;
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            araddr_q     <= 32'd0;
            arlen_q      <= 4'd0;
            arsize_q     <= 3'd0;
            arburst_q    <= 2'd0;
            arvalid_q    <= 1'b0;
            awaddr_q     <= 32'd0;
            awlen_q      <= 4'd0;
            awsize_q     <= 3'd0;
            awburst_q    <= 2'd0;
            awvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            wdata_q      <= 64'd0;
            wstrb_q      <= 64'd0;
            wlast_q      <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        line_q <= req_wdata_i;
                        rbuf_q <= '0;
                        cnt_q  <= 4'd0;
                        err_q  <= 1'b0;
                        if (req_wen_i) begin
                            awaddr_q  <= req_addr_i & ADDR_MASK;
                            awlen_q   <= LAST;
                            awsize_q  <= 3'b011;
                            awburst_q <= 2'b01;
                            awvalid_q <= 1'b1;
                            state_q   <= S_AW;
                        end else begin
                            araddr_q  <= req_addr_i & ADDR_MASK;
                            arlen_q   <= LAST;
                            arsize_q  <= 3'b011;
                            arburst_q <= 2'b01;
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        rbuf_q[cnt_q[IW-1:0]] <= rdata_i;
                        if (rerr_s) begin
                            err_q <= 1'b1;
                        end
                        // A responder-signalled rlast ends the burst early.
                        if (rlast_i || (cnt_q == LAST)) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= err_q | rerr_s;
                            resp_rdata_q <= rline_d;
                            state_q      <= S_RESP;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_AW: begin
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= line_q[0];
                        wstrb_q   <= {64{1'b1}};
                        wlast_q   <= (LAST == 4'd0);
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (wready_i) begin
                        if (cnt_q == LAST) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            wstrb_q  <= 64'd0;
                            bready_q <= 1'b1;
                            state_q  <= S_B;
                        end else begin
                            cnt_q   <= cnt_d;
                            wdata_q <= line_q[cnt_d[IW-1:0]];
                            wlast_q <= (cnt_d == LAST);
                        end
                    end
                end
                S_B: begin
                    if (bvalid_i) begin
                        bready_q     <= 1'b0;
                        err_q        <= err_q | berr_s;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q | berr_s;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign araddr_o     = araddr_q;
    assign arlen_o      = arlen_q;
    assign arsize_o     = arsize_q;
    assign arburst_o    = arburst_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign awaddr_o     = awaddr_q;
    assign awlen_o      = awlen_q;
    assign awsize_o     = awsize_q;
    assign awburst_o    = awburst_q;
    assign awvalid_o    = awvalid_q;
    assign wdata_o      = wdata_q;
    assign wstrb_o      = wstrb_q;
    assign wlast_o      = wlast_q;
    assign wvalid_o     = wvalid_q;
    assign bready_o     = bready_q;

endmodule

// File: tb/tb_ysyx_22051086_axi_master.sv
// Directed and randomized bursts against a beat-level responder model kept in the bench.
module tb_ysyx_22051086_axi_master;

    localparam int BEATS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid, req_ready, req_wen;
    logic [31:0]         req_addr;
    logic [64*BEATS-1:0] req_wdata;
    logic                resp_valid, resp_err;
    logic [64*BEATS-1:0] resp_rdata;
    logic [31:0]         araddr, awaddr;
    logic [3:0]          arlen, awlen;
    logic [2:0]          arsize, awsize;
    logic [1:0]          arburst, awburst;
    logic                arvalid, arready, awvalid, awready;
    logic [63:0]         rdata, wdata, wstrb;
    logic [1:0]          rresp, bresp;
    logic                rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] rd_line [BEATS];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22051086_axi_master #(.BEATS(BEATS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
        .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
        .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
        .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        logic [31:0] lb;
        lb = 32'(8 * BEATS);
        return (a / lb) * lb;
    endfunction

    // err_beat < 0 means a clean burst; last_beat < BEATS-1 means rlast arrives early
    task automatic do_read(input logic [31:0] addr, input int ar_stall, input int err_beat,
                           input int last_beat, input bit gaps, input bit fixed);
        logic [63:0] exp_beat [BEATS];
        bit exp_err;
        int acc;
        exp_err = 1'b0;
        @(negedge clk);
        chk("rd_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0; acc = cyc;
        chk("ar_valid", 64'(arvalid), 64'd1);
        chk("ar_addr", 64'(araddr), 64'(align(addr)));
        chk("ar_len", 64'(arlen), 64'(BEATS - 1));
        chk("ar_size", 64'(arsize), 64'd3);
        chk("ar_burst", 64'(arburst), 64'd1);
        chk("ar_no_aw", 64'(awvalid), 64'd0);
        chk("ar_no_rready", 64'(rready), 64'd0);
        arready = (ar_stall == 0);
        for (int i = 1; i <= ar_stall; i++) begin
            @(negedge clk);
            chk("ar_hold_valid", 64'(arvalid), 64'd1);
            chk("ar_hold_addr", 64'(araddr), 64'(align(addr)));
            chk("ar_stall_rready", 64'(rready), 64'd0);
            if (i == ar_stall) arready = 1'b1;
        end
        @(negedge clk);
        arready = 1'b0;
        chk("r_rready", 64'(rready), 64'd1);
        chk("r_arvalid_low", 64'(arvalid), 64'd0);
        for (int b = 0; b <= last_beat; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                rvalid = 1'b0;
                @(negedge clk);
                chk("r_gap_rready", 64'(rready), 64'd1);
                chk("r_gap_no_resp", 64'(resp_valid), 64'd0);
            end
            exp_beat[b] = fixed ? {8{8'(8'h11 * (b + 1))}} : {$urandom, $urandom};
            rvalid = 1'b1;
            rdata  = exp_beat[b];
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == last_beat);
            if (b == err_beat) exp_err = 1'b1;
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        chk("rd_resp_valid", 64'(resp_valid), 64'd1);
        chk("rd_resp_err", 64'(resp_err), 64'(exp_err));
        chk("rd_rready_low", 64'(rready), 64'd0);
        for (int b = 0; b <= last_beat; b++) begin
            chk($sformatf("rd_beat%0d", b), resp_rdata[64*b +: 64], exp_beat[b]);
            if (last_beat == BEATS - 1) rd_line[b] = exp_beat[b];
        end
        if (ar_stall == 0 && !gaps) chk("rd_latency", 64'(cyc - acc + 1), 64'(last_beat + 3));
        @(negedge clk);
        chk("rd_pulse_one", 64'(resp_valid), 64'd0);
        chk("rd_back_idle", 64'(req_ready), 64'd1);
    endtask

    // mode 0: wready always high, 1: pattern 1,0,1,1,0,1, 2: random
    task automatic do_write(input logic [31:0] addr, input int mode, input int bdelay,
                            input logic [1:0] br);
        logic [63:0] d [BEATS];
        logic [5:0] pat;
        int acc, beat, p;
        pat = 6'b101101;
        for (int k = 0; k < BEATS; k++) begin
            d[k] = {$urandom, $urandom};
            req_wdata[64*k +: 64] = d[k];
        end
        @(negedge clk);
        chk("wr_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0; acc = cyc;
        chk("aw_valid", 64'(awvalid), 64'd1);
        chk("aw_addr", 64'(awaddr), 64'(align(addr)));
        chk("aw_len", 64'(awlen), 64'(BEATS - 1));
        chk("aw_size", 64'(awsize), 64'd3);
        chk("aw_burst", 64'(awburst), 64'd1);
        chk("aw_no_ar", 64'(arvalid), 64'd0);
        chk("aw_no_wvalid", 64'(wvalid), 64'd0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        beat = 0; p = 0;
        while (beat < BEATS && p < 64) begin
            case (mode)
                0:       wready = 1'b1;
                1:       wready = pat[p % 6];
                default: wready = (p >= 32) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            chk("w_valid", 64'(wvalid), 64'd1);
            chk($sformatf("w_data%0d", beat), wdata, d[beat]);
            chk("w_last", 64'(wlast), 64'(beat == BEATS - 1));
            chk("w_strb", wstrb, {64{1'b1}});
            chk("w_no_bready", 64'(bready), 64'd0);
            if (wready) beat++;
            p++;
            @(negedge clk);
        end
        chk("w_all_beats", 64'(beat), 64'(BEATS));
        wready = 1'b0;
        chk("b_wvalid_low", 64'(wvalid), 64'd0);
        chk("b_wlast_low", 64'(wlast), 64'd0);
        chk("b_bready", 64'(bready), 64'd1);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            chk("b_hold_bready", 64'(bready), 64'd1);
            chk("b_no_resp", 64'(resp_valid), 64'd0);
        end
        bvalid = 1'b1; bresp = br;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        chk("wr_resp_valid", 64'(resp_valid), 64'd1);
        chk("wr_resp_err", 64'(resp_err), 64'(br != 2'b00));
        chk("wr_bready_low", 64'(bready), 64'd0);
        if (mode == 0 && bdelay == 0) chk("wr_latency", 64'(cyc - acc + 1), 64'(BEATS + 3));
        @(negedge clk);
        chk("wr_pulse_one", 64'(resp_valid), 64'd0);
        chk("wr_back_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rdata = 64'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; bvalid = 1'b0;
        #12;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata[63:0], 64'd0);
        chk("rst_wlast", 64'(wlast), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_wstrb", wstrb, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        do_read(32'h8000_0010, 0, -1, BEATS - 1, 1'b0, 1'b1);
        do_write(32'h4000_1238, 1, 0, 2'b00);
        for (int b = 0; b < BEATS; b++)
            chk($sformatf("rdata_hold%0d", b), resp_rdata[64*b +: 64], rd_line[b]);
        do_read(32'h8000_2004, 5, -1, BEATS - 1, 1'b0, 1'b0);
        do_read($urandom, 0, 2, BEATS - 1, 1'b0, 1'b0);
        do_write($urandom, 0, 0, 2'b00);
        do_read($urandom, 0, -1, 2, 1'b0, 1'b0);

        // Reset while the write burst is stalled in its data phase
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h1000_0040;
        @(negedge clk);
        req_valid = 1'b0; awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        chk("rstw_in_w", 64'(wvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wvalid", 64'(wvalid), 64'd0);
        chk("rstw_bready", 64'(bready), 64'd0);
        chk("rstw_wstrb", wstrb, 64'd0);
        chk("rstw_awlen", 64'(awlen), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_req_ready", 64'(req_ready), 64'd1);
        chk("rstw_no_wvalid", 64'(wvalid), 64'd0);
        do_read($urandom, 0, -1, BEATS - 1, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                int eb;
                eb = int'($urandom_range(0, 5));
                do_read($urandom, int'($urandom_range(0, 3)), (eb < BEATS) ? eb : -1,
                        BEATS - 1, 1'b1, 1'b0);
            end else begin
                do_write($urandom, 2, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
